// File: rtl/quantum_scheduler.sv
// Round-robin context switcher driven by the preemption timer and process finish.
// Saves the running PC, picks the next active slot and drives PC, offset and quantum reloads.
module quantum_scheduler #(
  parameter int          NPROC       = 4,
  parameter int          ID_W        = 2,
  parameter logic [31:0] SLOT_WORDS  = 32'd256,
  parameter logic [31:0] DEF_QUANTUM = 32'd100
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            interrupt,
  input  logic            finish,
  input  logic [31:0]     pc_current,
  input  logic            create_valid,
  input  logic [ID_W-1:0] create_id,
  input  logic [31:0]     create_pc,
  input  logic [31:0]     create_quantum,
  output logic            pc_load,
  output logic [31:0]     pc_next,
  output logic [31:0]     im_offset,
  output logic            timer_load,
  output logic [31:0]     quantum,
  output logic [ID_W-1:0] active_id,
  output logic            switching,
  output logic            idle
);

  typedef enum logic [1:0] {IDLE, SELECT, LOAD, RUN} state_t;

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  cur_reg, cur_next;
  logic [NPROC-1:0] active_reg, active_next;
  logic [31:0]      pc_table [NPROC];
  logic [31:0]      q_table  [NPROC];

  logic             found;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  probe;
  logic             save_pc;
  logic [31:0]      create_q;
  logic [31:0]      cur_ext;

  assign save_pc  = (state_reg == RUN) && !finish && interrupt;
  assign create_q = (create_quantum == 32'd0) ? DEF_QUANTUM : create_quantum;

  // Descending probe order so the nearest slot after cur wins; k == NPROC wraps to cur itself.
  always_comb begin
    found = 1'b0;
    pick  = cur_reg;
    probe = cur_reg;
    for (int k = NPROC; k >= 1; k--) begin
      probe = cur_reg + ID_W'(k);
      if (active_reg[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  // Create is applied after finish so a same-slot create keeps the slot alive.
  always_comb begin
    active_next = active_reg;
    if ((state_reg == RUN) && finish)
      active_next[cur_reg] = 1'b0;
    if (create_valid)
      active_next[create_id] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    case (state_reg)
      IDLE:   if (|active_next) state_next = SELECT;
      SELECT: begin
        if (found) begin
          cur_next   = pick;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD:   state_next = RUN;
      RUN:    if (finish || interrupt) state_next = SELECT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cur_reg    <= '0;
      active_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cur_reg    <= cur_next;
      active_reg <= active_next;
    end
  end

  // A create to the same slot lands after the PC save, so the new start PC wins.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        pc_table[i] <= '0;
        q_table[i]  <= '0;
      end
    end else begin
      if (save_pc)
        pc_table[cur_reg] <= pc_current;
      if (create_valid) begin
        pc_table[create_id] <= create_pc;
        q_table[create_id]  <= create_q;
      end
    end
  end

  assign cur_ext    = 32'(cur_reg);
  assign pc_load    = (state_reg == LOAD);
  assign timer_load = (state_reg == LOAD);
  assign pc_next    = (state_reg == LOAD) ? pc_table[cur_reg] : 32'd0;
  assign quantum    = (state_reg == LOAD) ? q_table[cur_reg]  : 32'd0;
  // cur only changes on entry to LOAD, so these hold their values outside it.
  assign active_id  = cur_reg;
  assign im_offset  = cur_ext * SLOT_WORDS;
  assign switching  = (state_reg == SELECT) || (state_reg == LOAD);
  assign idle       = (state_reg == IDLE);

endmodule

// File: tb/tb_quantum_scheduler.sv
// Scenario bench for quantum_scheduler with a slot-table reference model.
// Inputs change and outputs are sampled just after the rising edge; the DUT acts on the falling edge.
module tb_quantum_scheduler;
  localparam int NPROC = 4;
  localparam int ID_W  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            interrupt;
  logic            finish;
  logic [31:0]     pc_current;
  logic            create_valid;
  logic [ID_W-1:0] create_id;
  logic [31:0]     create_pc;
  logic [31:0]     create_quantum;
  logic            pc_load;
  logic [31:0]     pc_next;
  logic [31:0]     im_offset;
  logic            timer_load;
  logic [31:0]     quantum;
  logic [ID_W-1:0] active_id;
  logic            switching;
  logic            idle;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_pc [NPROC];
  logic [31:0] m_q  [NPROC];
  bit          m_act [NPROC];
  int          m_cur;
  bit          m_running;

  quantum_scheduler dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .finish(finish),
    .pc_current(pc_current), .create_valid(create_valid), .create_id(create_id),
    .create_pc(create_pc), .create_quantum(create_quantum), .pc_load(pc_load),
    .pc_next(pc_next), .im_offset(im_offset), .timer_load(timer_load),
    .quantum(quantum), .active_id(active_id), .switching(switching), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    interrupt = 0; finish = 0; pc_current = 0; create_valid = 0;
    create_id = 0; create_pc = 0; create_quantum = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NPROC; i++) begin
      m_pc[i] = 0; m_q[i] = 0; m_act[i] = 0;
    end
    m_cur = 0;
    m_running = 0;
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NPROC; k++)
      if (m_act[(m_cur + k) % NPROC]) return (m_cur + k) % NPROC;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    step();
    reset = 0;
    m_reset();
    step();
  endtask

  // Applies one falling edge of stimulus and the spec's table rules to the model.
  task automatic do_edge(input bit iv, input bit fv, input logic [31:0] pcv,
                         input bit cv, input int cid, input logic [31:0] cpc,
                         input logic [31:0] cq, output bit trig);
    bit any_act;
    interrupt = iv; finish = fv; pc_current = pcv;
    create_valid = cv; create_id = ID_W'(cid); create_pc = cpc; create_quantum = cq;
    trig = 0;
    if (m_running) begin
      if (fv) begin
        m_act[m_cur] = 0; trig = 1;
      end else if (iv) begin
        m_pc[m_cur] = pcv; trig = 1;
      end
    end
    if (cv) begin
      m_pc[cid] = cpc; m_q[cid] = (cq == 0) ? 32'd100 : cq; m_act[cid] = 1;
    end
    any_act = 0;
    for (int i = 0; i < NPROC; i++) any_act |= m_act[i];
    if (!m_running && any_act) trig = 1;
    step();
    clear_inputs();
  endtask

  // Called right after a trigger edge: walks SELECT, then LOAD+RUN or IDLE.
  task automatic run_switch(input string tag, input bit noise);
    int pick;
    checks++;
    if ({pc_load, timer_load, switching, idle} !== 4'b0010) begin
      fails++; $display("FAIL %s select_flags got %b want 0010", tag, {pc_load, timer_load, switching, idle});
    end
    pick = rr_pick();
    if (noise) begin
      interrupt = 1; finish = 1; pc_current = $urandom;
    end
    step();
    if (pick >= 0) begin
      m_cur = pick;
      m_running = 1;
      checks++;
      if ({pc_load, timer_load, switching, idle} !== 4'b1110) begin
        fails++; $display("FAIL %s load_flags got %b want 1110", tag, {pc_load, timer_load, switching, idle});
      end
      checks++;
      if (pc_next !== m_pc[pick]) begin
        fails++; $display("FAIL %s pc_next got %h want %h", tag, pc_next, m_pc[pick]);
      end
      checks++;
      if (quantum !== m_q[pick]) begin
        fails++; $display("FAIL %s quantum got %0d want %0d", tag, quantum, m_q[pick]);
      end
      checks++;
      if (active_id !== ID_W'(pick) || im_offset !== 32'(pick * 256)) begin
        fails++; $display("FAIL %s id/offset got %0d/%0d want %0d/%0d", tag, active_id, im_offset, pick, pick * 256);
      end
      step();
      clear_inputs();
      checks++;
      if ({pc_load, timer_load, switching, idle} !== 4'b0000 || active_id !== ID_W'(pick)) begin
        fails++; $display("FAIL %s run_flags got %b id %0d want 0000 id %0d", tag, {pc_load, timer_load, switching, idle}, active_id, pick);
      end
      $display("switch %s -> id %0d pc %h q %0d", tag, pick, m_pc[pick], m_q[pick]);
    end else begin
      m_running = 0;
      clear_inputs();
      checks++;
      if ({pc_load, timer_load, switching, idle} !== 4'b0001 || active_id !== ID_W'(m_cur)) begin
        fails++; $display("FAIL %s idle_flags got %b id %0d want 0001 id %0d", tag, {pc_load, timer_load, switching, idle}, active_id, m_cur);
      end
      $display("switch %s -> idle", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    step(); step();
    checks++;
    if ({pc_load, timer_load, switching, idle} !== 4'b0001 || pc_next !== 0 ||
        im_offset !== 0 || quantum !== 0 || active_id !== 0) begin
      fails++; $display("FAIL reset_outputs flags %b pc %h off %h q %h id %0d",
                        {pc_load, timer_load, switching, idle}, pc_next, im_offset, quantum, active_id);
    end
    reset = 0;
    m_reset();
    step();
    checks++;
    if ({pc_load, timer_load, idle} !== 3'b001) begin
      fails++; $display("FAIL reset_release flags got %b want 001", {pc_load, timer_load, idle});
    end
    $display("reset checked");
  endtask

  task automatic test_first_process();
    bit trig;
    do_edge(0, 0, 0, 1, 0, 32'h10, 32'd5, trig);
    run_switch("first_create", 0);
  endtask

  task automatic test_two_procs();
    bit trig;
    do_edge(0, 0, 0, 1, 2, $urandom, $urandom_range(1, 500), trig);
    checks++;
    if ({switching, idle} !== 2'b00 || active_id !== 0) begin
      fails++; $display("FAIL create_no_preempt flags %b id %0d want 00 id 0", {switching, idle}, active_id);
    end
    do_edge(1, 0, 32'h24, 0, 0, 0, 0, trig);
    run_switch("int_to_2", 0);
    do_edge(1, 0, $urandom, 0, 0, 0, 0, trig);
    run_switch("int_back_to_0", 0);
  endtask

  task automatic test_finish_to_idle();
    bit trig;
    do_reset();
    do_edge(0, 0, 0, 1, 1, $urandom, $urandom_range(1, 50), trig);
    run_switch("create_1", 0);
    do_edge(0, 1, 0, 0, 0, 0, 0, trig);
    run_switch("finish_last", 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pc_load, timer_load, switching, idle} !== 4'b0001) begin
        fails++; $display("FAIL stay_idle flags got %b want 0001", {pc_load, timer_load, switching, idle});
      end
    end
  endtask

  task automatic test_single_reselect();
    bit trig;
    do_reset();
    do_edge(0, 0, 0, 1, 3, 32'h40, 32'd9, trig);
    run_switch("create_3", 0);
    do_edge(1, 0, 32'h7, 0, 0, 0, 0, trig);
    run_switch("reselect_3", 0);
  endtask

  task automatic test_int_fin_same_edge();
    bit trig;
    do_reset();
    do_edge(0, 0, 0, 1, 0, 32'h100, 32'd20, trig);
    run_switch("create_0", 0);
    do_edge(0, 0, 0, 1, 1, 32'h200, 32'd30, trig);
    do_edge(1, 1, 32'hdead, 0, 0, 0, 0, trig);
    run_switch("int_fin_noise", 1);
    do_edge(1, 0, 32'h234, 0, 0, 0, 0, trig);
    run_switch("only_1_left", 0);
  endtask

  task automatic test_create_overrides();
    bit trig;
    do_edge(0, 1, 0, 1, 1, 32'h300, 32'd0, trig);
    run_switch("finish_vs_create", 0);
    do_edge(1, 0, 32'h999, 1, 1, 32'h444, 32'd7, trig);
    run_switch("save_vs_create", 0);
  endtask

  task automatic test_random();
    bit trig;
    int r, cid;
    bit cv, iv, fv;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      cid = $urandom_range(0, NPROC - 1);
      if (!m_running) begin
        do_edge(0, 0, 0, 1, cid, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 1000), trig);
        run_switch("rnd_wake", 0);
      end else begin
        r  = $urandom_range(0, 5);
        cv = ($urandom_range(0, 2) == 0) || (r == 5);
        iv = (r == 1) || (r == 2) || (r == 4);
        fv = (r == 3) || (r == 4);
        do_edge(iv, fv, $urandom, cv, cid, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 1000), trig);
        if (trig) begin
          run_switch("rnd_trig", $urandom_range(0, 1));
        end else begin
          checks++;
          if ({pc_load, timer_load, switching, idle} !== 4'b0000 || active_id !== ID_W'(m_cur)) begin
            fails++; $display("FAIL rnd_stay flags %b id %0d want 0000 id %0d", {pc_load, timer_load, switching, idle}, active_id, m_cur);
          end
          $display("rnd hold id %0d", m_cur);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bit trig;
    do_reset();
    do_edge(0, 0, 0, 1, 2, $urandom, 32'd0, trig);
    step();
    checks++;
    if (pc_load !== 1'b1 || quantum !== 32'd100 || im_offset !== 32'd512) begin
      fails++; $display("FAIL default_quantum load %b q %0d off %0d want 1 100 512", pc_load, quantum, im_offset);
    end
    reset = 1;
    #1;
    checks++;
    if ({pc_load, timer_load, switching, idle} !== 4'b0001 || pc_next !== 0 ||
        im_offset !== 0 || quantum !== 0 || active_id !== 0) begin
      fails++; $display("FAIL reset_mid_load flags %b pc %h off %h q %h id %0d",
                        {pc_load, timer_load, switching, idle}, pc_next, im_offset, quantum, active_id);
    end
    step();
    reset = 0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pc_load, timer_load, switching, idle} !== 4'b0001) begin
        fails++; $display("FAIL after_reset flags got %b want 0001", {pc_load, timer_load, switching, idle});
      end
    end
    $display("reset during LOAD checked");
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    m_reset();
    test_reset();
    test_first_process();
    test_two_procs();
    test_finish_to_idle();
    test_single_reselect();
    test_int_fin_same_edge();
    test_create_overrides();
    test_random();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/quantum_scheduler.md
Name: quantum_scheduler

Overview:
- Consumer of the preemption timer's interrupt. Performs round-robin context switches between up to NPROC resident processes.
- On timer interrupt or process finish, it:
  - saves the running PC,
  - selects the next active process,
  - drives the new PC and instruction-memory offset into the fetch stage,
  - reloads the timer with that process's quantum via timer_load.
- Sits between the timer, the PC register and the OS-facing process-creation path.

Parameters:
- NPROC, 4, number of process slots (power of 2).
- ID_W, 2, width of a process id (log2 NPROC).
- SLOT_WORDS, 32'd256, instruction-memory words per process; im_offset = id*SLOT_WORDS.
- DEF_QUANTUM, 32'd100, quantum used when create_quantum is 0.

Ports:
- clock  in  1  system clock; all state updates on negedge, same edge as the timer.
- reset  in  1  asynchronous, active-high.
- interrupt  in  1  one-cycle preemption pulse from the timer.
- finish  in  1  current process executed its terminating instruction.
- pc_current  in  32  PC of the running process.
- create_valid  in  1  register a process this cycle.
- create_id  in  ID_W  slot to fill.
- create_pc  in  32  start PC (relative to the slot's offset).
- create_quantum  in  32  slice length; 0 selects DEF_QUANTUM.
- pc_load  out  1  one-cycle strobe: load pc_next into the PC.
- pc_next  out  32  restored PC.
- im_offset  out  32  base offset of the running process.
- timer_load  out  1  one-cycle strobe to the timer's quantum-load input.
- quantum  out  32  value to load into the timer; valid while timer_load is high.
- active_id  out  ID_W  currently running slot.
- switching  out  1  CPU must stall (state SELECT or LOAD).
- idle  out  1  no runnable process (state IDLE).

Behaviour:
- Storage: pc_table[NPROC] x32, q_table[NPROC] x32, active[NPROC] bits, cur (ID_W), state.
- States: IDLE, SELECT, LOAD, RUN.
- Reset (async): state=IDLE, active=0, cur=0, tables=0. Outputs: pc_load=0, pc_next=0, im_offset=0, timer_load=0, quantum=0, active_id=0, switching=0, idle=1.
- Create:
  - create_valid is accepted in every state.
  - At the edge: pc_table[create_id]=create_pc, q_table[create_id]=create_quantum or DEF_QUANTUM, active[create_id]=1.
  - Creating the running slot overwrites its table entries without preempting it.
- IDLE:
  - If any active bit is set (including one set this edge by create), go to SELECT.
  - Search starts from cur+1.
- RUN:
  - finish (priority over interrupt): active[cur]=0, no PC save, go to SELECT.
  - Else interrupt: pc_table[cur]=pc_current at that same edge, go to SELECT.
  - Else stay in RUN.
- SELECT:
  - Round-robin search for an active slot over cur+1, cur+2, … wrapping mod NPROC, ending with cur itself (checked last).
  - Found: cur=that id, go to LOAD.
  - None found: go to IDLE.
  - interrupt/finish are ignored in this state.
- LOAD (Moore outputs, exactly one cycle):
  - pc_load=1, pc_next=pc_table[cur], timer_load=1, quantum=q_table[cur].
  - im_offset=cur*SLOT_WORDS (low 32 bits), active_id=cur.
  - Next state: RUN.
  - interrupt/finish are ignored in this state.
- Outputs and latency:
  - im_offset and active_id hold their values outside LOAD.
  - switching=1 in SELECT and LOAD; idle=1 only in IDLE.
  - Latency: trigger seen at edge N → LOAD is the state during cycle N+1 to N+2 → pc_load/timer_load sampled at edge N+2 → RUN from edge N+2.
- Single-active case: an interrupt re-selects the same slot. It reloads its own saved PC and restarts its quantum.
- Create in the same edge as finish for the same slot: create wins (active stays 1, new PC stored). The finish still triggers SELECT.
- Create in the same edge as a save for the same slot: create's PC wins.
- Reset asserted mid-switch returns to IDLE immediately. pc_load and timer_load must never be high on the cycle after reset deasserts.

Test Plan:
- Reset, then create id0 pc=0x10 q=5 → SELECT, LOAD with pc_next=0x10, im_offset=0, quantum=5, timer_load=1 for 1 cycle; idle falls to 0.
- Ids 0 and 2 active, running 0 with pc_current=0x24, interrupt pulse → pc_table[0]=0x24; LOAD shows active_id=2, im_offset=512. Next interrupt returns to 0 with pc_next=0x24.
- Only id1 active, finish → active[1]=0, SELECT → IDLE, idle=1, no pc_load or timer_load.
- Only id3 active, interrupt with pc_current=0x7 → reselects id3, pc_next=0x7, timer_load pulses.
- interrupt and finish on the same edge → finish path taken (slot deactivated, PC not saved); an interrupt during SELECT is ignored.
- Reset asserted during LOAD → all outputs zero immediately, active cleared, idle=1; create_quantum=0 → quantum=100.
